// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_sb
// Brief    : Multi-read-port register file with byte-enabled writeback,
//            write-to-read bypass and a per-register busy scoreboard.
// Revision : 1.0
// ============================================================================
module reg_file_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int RPORTS = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS),
  localparam int CW    = $clog2(NREGS) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [RPORTS*AW-1:0]     rd_addr,
  output logic [RPORTS*XLEN-1:0]   rd_data,
  output logic [RPORTS-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  input  logic [XLEN/8-1:0]        wr_be,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  output logic                     rsv_ok,
  input  logic                     flush,
  output logic [CW-1:0]            busy_cnt
);

  localparam int NB = XLEN / 8;

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [CW-1:0]    r_cnt;

  logic             w_wr_hit;
  logic             w_rsv_ok;
  logic             w_rsv_set;
  logic             w_inc;
  logic             w_dec;
  logic [XLEN-1:0]  w_wr_merged;

  always_comb begin
    w_wr_merged = r_regs[wr_addr];
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) w_wr_merged[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  assign w_wr_hit  = wr_en && (wr_addr != '0);
  assign w_rsv_ok  = rsv_en && !flush &&
                     ((rsv_addr == '0) || !r_busy[rsv_addr] || (wr_en && (wr_addr == rsv_addr)));
  assign w_rsv_set = w_rsv_ok && (rsv_addr != '0);

  // Same-register write+reserve leaves the bit set, so it must not count as a clear.
  assign w_inc = w_rsv_set && !r_busy[rsv_addr];
  assign w_dec = w_wr_hit && r_busy[wr_addr] && !(w_rsv_set && (rsv_addr == wr_addr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr_hit) r_regs[wr_addr] <= w_wr_merged;
      if (flush) begin
        r_busy <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_wr_hit)  r_busy[wr_addr]  <= 1'b0;
        if (w_rsv_set) r_busy[rsv_addr] <= 1'b1;
        if (w_inc && !w_dec)      r_cnt <= r_cnt + CW'(1);
        else if (w_dec && !w_inc) r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign rsv_ok   = w_rsv_ok;
  assign busy_cnt = r_cnt;

  for (genvar p = 0; p < RPORTS; p++) begin : g_rd
    logic [AW-1:0]   w_a;
    logic            w_byp;
    logic [XLEN-1:0] w_d;
    logic            w_b;

    assign w_a   = rd_addr[p*AW +: AW];
    assign w_byp = (BYPASS != 0) && wr_en && (wr_addr == w_a);

    always_comb begin
      w_d = r_regs[w_a];
      w_b = r_busy[w_a];
      if (w_a == '0) begin
        w_d = '0;
        w_b = 1'b0;
      end else if (w_byp) begin
        w_d = w_wr_merged;
        w_b = 1'b0;
      end
    end

    assign rd_data[p*XLEN +: XLEN] = w_d;
    assign rd_busy[p]              = w_b;
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_sb
// Brief    : Scoreboard bench for reg_file_sb, bypass and non-bypass builds.
// Revision : 1.0
// ============================================================================
module tb_reg_file_sb;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int RP = 2;

  typedef struct {
    int          st;
    logic [63:0] d1;
    logic [63:0] d0;
    logic [1:0]  b1;
    logic [1:0]  b0;
    logic        ok;
    logic [5:0]  cnt;
    bit          kv;
    logic [31:0] kd;
  } exp_t;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  rd_addr = '0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        rsv_en = 1'b0;
  logic [4:0]  rsv_addr = '0;
  logic        flush = 1'b0;

  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic        rsv_ok_b, rsv_ok_n;
  logic [5:0]  cnt_b, cnt_n;

  int total = 0;
  int bad = 0;
  int stepn = 0;
  exp_t q[$];

  logic [31:0] m_regs [NREGS];
  bit          m_busy [NREGS];

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .RPORTS(RP), .BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok_b), .flush(flush), .busy_cnt(cnt_b));

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .RPORTS(RP), .BYPASS(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok_n), .flush(flush), .busy_cnt(cnt_n));

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  function automatic void chk(string nm, int st, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", nm, st, act, exp);
    end
  endfunction

  // Reference model: architectural view of the register file.
  function automatic void m_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic logic [31:0] m_read(int a, bit byp);
    logic [31:0] v;
    if (a == 0) return 32'h0;
    v = m_regs[a];
    if (byp && wr_en && (int'(wr_addr) == a))
      for (int i = 0; i < 4; i++) if (wr_be[i]) v[8*i +: 8] = wr_data[8*i +: 8];
    return v;
  endfunction

  function automatic logic m_bsy(int a, bit byp);
    if (a == 0) return 1'b0;
    if (byp && wr_en && (int'(wr_addr) == a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic m_ok();
    return rsv_en && !flush &&
           (rsv_addr == 0 || !m_busy[rsv_addr] || (wr_en && wr_addr == rsv_addr));
  endfunction

  function automatic logic [5:0] m_cnt();
    int n = 0;
    for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
    return 6'(n);
  endfunction

  task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [3:0] be, input logic re, input logic [4:0] ra,
                      input logic fl, input logic [4:0] a0, input logic [4:0] a1,
                      input bit kv, input logic [31:0] kd);
    exp_t e;
    logic ok;
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rsv_en = re; rsv_addr = ra; flush = fl; rd_addr = {a1, a0};
    stepn++;
    ok = m_ok();
    e.st  = stepn;
    e.d1  = {m_read(int'(a1), 1'b1), m_read(int'(a0), 1'b1)};
    e.d0  = {m_read(int'(a1), 1'b0), m_read(int'(a0), 1'b0)};
    e.b1  = {m_bsy(int'(a1), 1'b1), m_bsy(int'(a0), 1'b1)};
    e.b0  = {m_bsy(int'(a1), 1'b0), m_bsy(int'(a0), 1'b0)};
    e.ok  = ok;
    e.cnt = m_cnt();
    e.kv  = kv;
    e.kd  = kd;
    q.push_back(e);
    @(posedge clk);
    if (rst_n) begin
      if (we && wa != 0) m_regs[wa] = m_read(int'(wa), 1'b1);
      if (fl) begin
        for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
      end else begin
        if (we && wa != 0) m_busy[wa] = 1'b0;
        if (ok && ra != 0) m_busy[ra] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic rnd_steps(input int n);
    for (int i = 0; i < n; i++)
      step(1'($urandom % 2), 5'($urandom % 8), $urandom, 4'($urandom % 16),
           1'($urandom % 2), 5'($urandom % 8), 1'(($urandom % 16) == 0),
           5'($urandom % 8), 5'($urandom % 8), 1'b0, 32'h0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rd_data_byp", e.st, rd_data_b, e.d1);
      chk("rd_busy_byp", e.st, 64'(rd_busy_b), 64'(e.b1));
      chk("rd_data_nobyp", e.st, rd_data_n, e.d0);
      chk("rd_busy_nobyp", e.st, 64'(rd_busy_n), 64'(e.b0));
      chk("rsv_ok_byp", e.st, 64'(rsv_ok_b), 64'(e.ok));
      chk("rsv_ok_nobyp", e.st, 64'(rsv_ok_n), 64'(e.ok));
      chk("busy_cnt_byp", e.st, 64'(cnt_b), 64'(e.cnt));
      chk("busy_cnt_nobyp", e.st, 64'(cnt_n), 64'(e.cnt));
      if (e.kv) chk("known_value", e.st, 64'(rd_data_b[31:0]), 64'(e.kd));
    end
  end

  initial begin
    m_reset();
    #2 rst_n = 1'b0;
    #2;
    for (int a = 0; a < NREGS; a++) begin
      rd_addr = {5'(a), 5'(a)};
      #1;
      chk("reset_data", a, rd_data_b | rd_data_n, 64'h0);
      chk("reset_busy", a, 64'(rd_busy_b | rd_busy_n), 64'h0);
    end
    chk("reset_cnt", 0, 64'(cnt_b | cnt_n), 64'h0);
    rst_n = 1'b1;
    #1 clk_en = 1'b1;
    @(posedge clk);
    #1;

    step(1, 5, 32'hDEADBEEF, 4'hF, 0, 0, 0, 5, 5, 1, 32'hDEADBEEF);
    step(1, 5, 32'h11223344, 4'h5, 0, 0, 0, 5, 0, 1, 32'hDE22BE44);
    step(0, 0, 0, 0, 0, 0, 0, 5, 5, 1, 32'hDE22BE44);

    step(0, 0, 0, 0, 1, 7, 0, 7, 0, 0, 0);
    step(0, 0, 0, 0, 1, 7, 0, 7, 7, 0, 0);
    step(1, 7, 32'hA5A5A5A5, 4'hF, 1, 7, 0, 7, 0, 0, 0);
    step(1, 7, 32'h00000077, 4'h1, 0, 0, 0, 7, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 7, 0, 1, 32'hA5A5A577);

    step(1, 0, 32'hFFFFFFFF, 4'hF, 1, 0, 0, 0, 0, 1, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0);

    step(0, 0, 0, 0, 1, 1, 0, 1, 2, 0, 0);
    step(0, 0, 0, 0, 1, 2, 0, 1, 2, 0, 0);
    step(0, 0, 0, 0, 1, 3, 0, 3, 2, 0, 0);
    step(1, 2, 32'h5, 4'hF, 1, 4, 1, 2, 4, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 2, 4, 1, 32'h5);

    rnd_steps(300);

    step(1, 9, 32'h1234, 4'hF, 0, 0, 0, 9, 0, 0, 0);
    step(0, 0, 0, 0, 1, 9, 0, 9, 9, 0, 0);
    rst_n = 1'b0;
    m_reset();
    step(0, 0, 0, 0, 0, 0, 0, 9, 9, 1, 32'h0);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 9, 9, 1, 32'h0);

    rnd_steps(100);

    repeat (2) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-read-port register file with byte-enabled writeback, write-to-read bypass, and an integrated per-register busy scoreboard. It is the next-generation architectural register file for the RISC-V datapath. Decode reserves a destination register, and writeback clears that reservation. Read ports report both operand data and a busy flag, so the hazard unit can stall without keeping a separate scoreboard.

## Interface
- XLEN, 32, register width in bits; must be a multiple of 8.
- NREGS, 32, number of registers; power of two, ≥ 2.
- RPORTS, 2, number of independent read ports.
- BYPASS, 1, 1 = same-cycle write data is forwarded to reads; 0 = reads return stored contents only.
- AW (localparam) = log2(NREGS); CW (localparam) = log2(NREGS)+1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_addr  in  RPORTS*AW  read addresses; port p occupies bits [p*AW +: AW].
- rd_data  out  RPORTS*XLEN  read data, combinational; port p occupies [p*XLEN +: XLEN].
- rd_busy  out  RPORTS  scoreboard busy flag per read port, combinational.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback destination.
- wr_data  in  XLEN  writeback data.
- wr_be  in  XLEN/8  byte enables; bit i covers wr_data[8i+7:8i].
- rsv_en  in  1  reservation request from decode.
- rsv_addr  in  AW  register to reserve.
- rsv_ok  out  1  reservation accepted this cycle, combinational.
- flush  in  1  clears every busy bit (pipeline squash).
- busy_cnt  out  CW  count of busy registers, registered.

## Operation
- Storage: NREGS×XLEN array plus an NREGS-bit busy vector.
- Register 0 is hardwired zero:
  - reads return 0 and rd_busy = 0;
  - writes are discarded;
  - a reservation of register 0 is accepted (rsv_ok = 1) but never sets busy.
- Write: when wr_en is high and wr_addr ≠ 0, each byte with wr_be[i] = 1 is replaced and the other bytes are kept. busy[wr_addr] clears on the same edge, even when wr_be = 0.
- Reservation rule: rsv_ok = rsv_en & ~flush & (rsv_addr == 0 | ~busy[rsv_addr] | (wr_en & wr_addr == rsv_addr)).
  - An accepted reservation of a nonzero register sets busy[rsv_addr] at the edge.
  - A rejected reservation changes no state; decode must retry.
- Write and reservation to the same register in the same cycle: the data is written and busy ends at 1, so the new reservation wins.
- Flush: all busy bits clear at the edge and any reservation that cycle is dropped (rsv_ok = 0). A write in a flush cycle still updates data.
- Read, port p, with a = rd_addr[p]:
  - a == 0: rd_data = 0, rd_busy = 0.
  - BYPASS = 1 and wr_en and wr_addr == a: rd_data is the byte-merge of wr_data (enabled bytes) and the stored value (other bytes); rd_busy = 0.
  - Otherwise: rd_data = regs[a] and rd_busy = busy[a].
- All ports are independent. Identical addresses on several ports return identical results.
- busy_cnt equals the population count of the busy vector after each edge. It is maintained incrementally with a net change in {−1, 0, +1}, or reloaded to 0 on flush.

## Timing
- Reset (asynchronous assert, synchronous release): all registers 0, busy vector 0, busy_cnt 0.
  - Consequently rd_data = 0 and rd_busy = 0 on every port.
  - rsv_ok stays combinational and may be 1 during reset, but no state changes while rst_n = 0.
- Reset asserted mid-operation discards all reservations and data at once; there is no partial write.
- Read latency is 0 cycles (combinational). Write-to-read latency is 0 cycles with BYPASS = 1 and 1 cycle with BYPASS = 0.
- Reservation takes effect at the edge: a read of the reserved register shows rd_busy = 1 from the next cycle.
- A writeback clears busy at the edge. With BYPASS = 1 the writeback cycle itself already shows rd_busy = 0.
- busy_cnt reflects the state after the most recent edge, with no combinational path from inputs.

## Test plan
- Reset then reads: pulse rst_n low with clk stopped, read all addresses -> every rd_data = 0x00000000, every rd_busy = 0, busy_cnt = 0.
- Byte write + bypass:
  - Write x5 = 0xDEADBEEF with wr_be = 4'hF.
  - Next cycle, write wr_data = 0x11223344 with wr_be = 4'b0101 while reading x5 -> same-cycle rd_data = 0xDE22BE44.
  - With BYPASS = 0 the same cycle returns 0xDEADBEEF and the next cycle returns 0xDE22BE44.
- Scoreboard:
  - Reserve x7 -> rsv_ok = 1; next cycle rd_busy = 1 and busy_cnt = 1.
  - Reserve x7 again -> rsv_ok = 0.
  - Writeback x7 while reserving x7 -> rsv_ok = 1 and busy_cnt stays 1.
  - Writeback x7 alone -> busy_cnt = 0.
- x0 handling: write x0 = 0xFFFFFFFF, reserve x0 -> rsv_ok = 1, busy_cnt unchanged; read x0 on both ports -> rd_data = 0, rd_busy = 0.
- Flush:
  - Reserve x1, x2, x3 -> busy_cnt = 3.
  - Assert flush together with rsv_en on x4 and a write of x2 = 0x5 -> rsv_ok = 0; next cycle busy_cnt = 0, x2 reads 0x5, x4 not busy.
- Mid-operation reset: with x9 = 0x1234 and x9 reserved, drop rst_n asynchronously between edges -> rd_data = 0, rd_busy = 0, busy_cnt = 0 immediately, before the next clk edge.
